// File: rtl/dwt_row_ctrl.sv
// dwt_row_ctrl
//
// Row controller that feeds a pixel stream into the sliding buffer of a 1-D
// DWT lifting stage. Each frame is HEIGHT rows of WIDTH pixels. Pixels are
// pushed into the buffer in even/odd pairs. Once LEN/2 pairs are resident and
// the buffer reports a freshly updated pair, the buffer window is offered to
// the lifting stage. While an offered window is not taken, the buffer is
// frozen.
//
// Optional feature, selected by the macro DWT_ROW_CTRL_FLUSH_EN:
//   defined   - after each row, LEN/2-1 zero pairs are pushed so the row's tail
//               pixels also reach the window (WIDTH/2 windows per row)
//   undefined - no padding (WIDTH/2-LEN/2+1 windows per row)
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//                      (assertion takes effect at once, release is synchronised)
//   start              one-cycle pulse that begins a frame (ignored while busy)
//   in_data/in_valid/in_ready     upstream pixel handshake
//   buf_enable/buf_clear/buf_data sliding-buffer control and pixel
//   buf_ready          buffer "pair updated" flag
//   out_valid/out_ready           window handshake with the lifting stage
//   row_done, frame_done          end-of-row / end-of-frame pulses
//   busy               high in every state except IDLE
module dwt_row_ctrl #(
  parameter int BW     = 8,
  parameter int LEN    = 4,
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [BW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          buf_enable,
  output logic          buf_clear,
  output logic [BW-1:0] buf_data,
  input  logic          buf_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          row_done,
  output logic          frame_done,
  output logic          busy
);

`ifdef DWT_ROW_CTRL_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  localparam int PW = $clog2(WIDTH/2 + LEN/2) + 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [PW-1:0] ONE_P     = PW'(1);
  localparam logic [PW-1:0] HALF_LEN  = PW'(LEN/2);
  localparam logic [PW-1:0] ROW_PAIRS = PW'(WIDTH/2);
  localparam logic [PW-1:0] LAST_PAIR = PW'(WIDTH/2 - 1);
  // Pairs pushed per row, including the zero pad pairs when padding is on.
  localparam logic [PW-1:0] ALL_PAIRS = FLUSH_EN ? PW'(WIDTH/2 + LEN/2 - 1) : PW'(WIDTH/2);
  // Windows the lifting stage must take before the row can close.
  localparam logic [PW-1:0] WIN_TOTAL = FLUSH_EN ? PW'(WIDTH/2) : PW'(WIDTH/2 - LEN/2 + 1);
  localparam logic [RW-1:0] ONE_R     = RW'(1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    ROWEND
  } state_t;

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [PW-1:0] pair_cnt_q, pair_cnt_d;
  logic [PW-1:0] win_cnt_q, win_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [1:0]    rst_sync_q, rst_sync_d;
  logic          rst_int_n;
  logic          stall;
  logic          consume;

  // Reset assertion passes straight through; release is delayed by two
  // clock edges so all state leaves reset on the same, clean edge.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      pair_cnt_q <= '0;
      win_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pair_cnt_q <= pair_cnt_d;
      win_cnt_q  <= win_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  // The pair count is registered, so it already reflects a pair one cycle
  // after that pair's odd-pixel enable, which is when the buffer raises
  // buf_ready for it.
  assign out_valid = buf_ready && (pair_cnt_q >= HALF_LEN);
  assign stall     = out_valid && !out_ready;
  assign consume   = out_valid && out_ready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pair_cnt_d = pair_cnt_q;
    win_cnt_d  = win_cnt_q;
    row_cnt_d  = row_cnt_q;
    in_ready   = 1'b0;
    buf_enable = 1'b0;
    buf_clear  = 1'b0;
    buf_data   = '0;
    row_done   = 1'b0;
    frame_done = 1'b0;

    if (consume) begin
      win_cnt_d = win_cnt_q + ONE_P;
    end

    case (state_q)
      IDLE: begin
        buf_clear = 1'b1;
        row_cnt_d = '0;
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        buf_clear  = 1'b1;
        phase_d    = 1'b0;
        pair_cnt_d = '0;
        win_cnt_d  = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (pair_cnt_q < ROW_PAIRS) begin
          in_ready   = in_valid && !stall;
          buf_enable = in_valid && !stall;
          buf_data   = in_data;
          if (FLUSH_EN && buf_enable && phase_q && (pair_cnt_q == LAST_PAIR)) begin
            state_d = FLUSH;
          end
        end else if (win_cnt_d == WIN_TOTAL) begin
          // Without padding the row is fully fed here; wait for the last window.
          state_d = ROWEND;
        end
      end
      FLUSH: begin
        if (pair_cnt_q < ALL_PAIRS) begin
          buf_enable = !stall;
        end else if (win_cnt_d == WIN_TOTAL) begin
          state_d = ROWEND;
        end
      end
      ROWEND: begin
        row_done = 1'b1;
        if (row_cnt_q == LAST_ROW) begin
          frame_done = 1'b1;
          row_cnt_d  = '0;
          state_d    = IDLE;
        end else begin
          row_cnt_d  = row_cnt_q + ONE_R;
          state_d    = CLEAR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Phase and pair count advance only on an actual push, so input gaps and
    // stalls freeze them.
    if (buf_enable) begin
      phase_d = !phase_q;
      if (phase_q) begin
        pair_cnt_d = pair_cnt_q + ONE_P;
      end
    end
  end

endmodule
